ssd1306_init_sequencer: RTL and testbench

Sequences the SSD1306 power-up program stored in `ssd1306_init_rom`: walks ROM addresses from 0 and decodes each 10-bit entry into a command byte, data byte, timed delay or end marker. Bytes go to the downstream serial byte transmitter (SPI/I2C) over a valid/ready handshake. Sits between the top-level display controller, which issues `start` and waits for `done`, and the transmitter. One instance per display.

---
 rtl/ssd1306_pkg.sv | 33 +++
 rtl/ssd1306_delay_timer.sv | 27 ++
 rtl/ssd1306_init_sequencer.sv | 124 ++++++++++++
 tb/tb_ssd1306_init_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ssd1306_pkg.sv
// rtl/ssd1306_pkg.sv - SSD1306 init ROM entry format, opcodes and sequencer states
package ssd1306_pkg;

    localparam int ENTRY_WIDTH = 10;
    localparam int OPCODE_MSB  = 9;
    localparam int OPCODE_LSB  = 8;
    localparam int ARG_MSB     = 7;
    localparam int ARG_LSB     = 0;

    typedef enum logic [1:0] {
        OP_CMD   = 2'b00,
        OP_DATA  = 2'b01,
        OP_DELAY = 2'b10,
        OP_END   = 2'b11
    } opcode_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_DELAY,
        S_DONE
    } state_t;

    function automatic opcode_t entry_opcode(input logic [ENTRY_WIDTH-1:0] entry);
        return opcode_t'(entry[OPCODE_MSB:OPCODE_LSB]);
    endfunction

    function automatic logic [7:0] entry_argument(input logic [ENTRY_WIDTH-1:0] entry);
        return entry[ARG_MSB:ARG_LSB];
    endfunction

endpackage

// File: rtl/ssd1306_delay_timer.sv
// rtl/ssd1306_delay_timer.sv - loadable down-counter with zero flag for init delays
module ssd1306_delay_timer #(
    parameter int COUNT_BITS = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [COUNT_BITS-1:0] load_value,
    output logic                  zero
);

    logic [COUNT_BITS-1:0] count;

    // Counter parks at zero once expired so a stale start cannot be missed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (start) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - COUNT_BITS'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/ssd1306_init_sequencer.sv
// rtl/ssd1306_init_sequencer.sv - walks the SSD1306 init ROM and feeds bytes to the transmitter
module ssd1306_init_sequencer
    import ssd1306_pkg::*;
#(
    parameter int ROM_SIZE          = 32,
    parameter int ADDRESS_BITS      = $clog2(ROM_SIZE),
    parameter int DELAY_UNIT_CYCLES = 12000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [ADDRESS_BITS-1:0] rom_address,
    input  logic [ENTRY_WIDTH-1:0]  rom_data,
    input  logic                    rom_overflow,
    output logic                    tx_valid,
    output logic [7:0]              tx_data,
    output logic                    tx_dc,
    input  logic                    tx_ready
);

    localparam int COUNT_BITS = $clog2(255 * DELAY_UNIT_CYCLES + 1);

    state_t                  state;
    state_t                  next_state;
    opcode_t                 opcode;
    logic [7:0]              argument;
    logic                    advance;
    logic                    timer_start;
    logic                    timer_zero;
    logic [COUNT_BITS-1:0]   delay_load_value;

    assign opcode   = entry_opcode(rom_data);
    assign argument = entry_argument(rom_data);

    // Counter runs argument*unit cycles, so it is loaded one short.
    assign delay_load_value = COUNT_BITS'(argument) * COUNT_BITS'(DELAY_UNIT_CYCLES)
                            - COUNT_BITS'(1);

    ssd1306_delay_timer #(
        .COUNT_BITS (COUNT_BITS)
    ) u_delay_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (timer_start),
        .load_value (delay_load_value),
        .zero       (timer_zero)
    );

    always_comb begin
        next_state  = state;
        advance     = 1'b0;
        timer_start = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) next_state = S_LOAD;
            end
            S_LOAD: begin
                if (rom_overflow || opcode == OP_END) begin
                    next_state = S_DONE;
                end else if (opcode == OP_CMD || opcode == OP_DATA) begin
                    next_state = S_SEND;
                end else if (argument != 8'd0) begin
                    next_state  = S_DELAY;
                    timer_start = 1'b1;
                end else begin
                    advance = 1'b1;
                end
            end
            S_SEND: begin
                if (tx_valid && tx_ready) begin
                    advance    = 1'b1;
                    next_state = S_LOAD;
                end
            end
            S_DELAY: begin
                if (timer_zero) begin
                    advance    = 1'b1;
                    next_state = S_LOAD;
                end
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    assign busy = (state == S_LOAD) || (state == S_SEND) || (state == S_DELAY);
    assign done = (state == S_DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            rom_address <= '0;
            tx_valid    <= 1'b0;
            tx_data     <= 8'd0;
            tx_dc       <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state == S_IDLE) begin
                rom_address <= '0;
            end else if (advance) begin
                rom_address <= rom_address + ADDRESS_BITS'(1);
            end
            if (state == S_LOAD && next_state == S_SEND) begin
                tx_valid <= 1'b1;
                tx_data  <= argument;
                tx_dc    <= (opcode == OP_DATA);
            end else if (state == S_SEND && tx_ready) begin
                tx_valid <= 1'b0;
            end
        end
    end

    // A full power-of-two ROM without an END entry would wrap back to 0 and loop.
    no_address_wrap: assert property (@(posedge clk) disable iff (!reset_n)
        !(advance && (&rom_address)))
        else $error("init ROM address wrapped: missing END entry");

endmodule

// File: tb/tb_ssd1306_init_sequencer.sv
// tb/tb_ssd1306_init_sequencer.sv - table-driven bench for ssd1306_init_sequencer
module tb_ssd1306_init_sequencer;

    localparam int ROM_SIZE = 5;
    localparam int AB       = 3;
    localparam int UNIT     = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          tx_ready = 1'b0;
    logic          busy, done, tx_valid, tx_dc, rom_overflow;
    logic [7:0]    tx_data;
    logic [AB-1:0] rom_address;
    logic [9:0]    rom_data;
    logic [9:0]    rom [0:7];

    ssd1306_init_sequencer #(
        .ROM_SIZE          (ROM_SIZE),
        .ADDRESS_BITS      (AB),
        .DELAY_UNIT_CYCLES (UNIT)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .rom_address  (rom_address),
        .rom_data     (rom_data),
        .rom_overflow (rom_overflow),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_dc        (tx_dc),
        .tx_ready     (tx_ready)
    );

    assign rom_data     = rom[rom_address];
    assign rom_overflow = (rom_address >= AB'(ROM_SIZE));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [8:0] hs_q [$];
    always @(posedge clk) if (reset_n && tx_valid && tx_ready) hs_q.push_back({tx_dc, tx_data});

    typedef struct packed {
        logic [4:0][9:0] rom;
        logic            always_ready;
        int              stall;
        int              repulse;
        int              n_bytes;
        logic [4:0][8:0] bytes;
        int              latency;
        int              first_valid;
    } vec_t;

    vec_t vecs [7];
    vec_t v_restart;

    int tests = 0;
    int fails = 0;
    int hold, stable_errs, busy_errs;
    bit wait_prev;
    logic [8:0] prev_byte;

    function automatic logic [9:0] c(input logic [7:0] a);  return {2'b00, a}; endfunction
    function automatic logic [9:0] d(input logic [7:0] a);  return {2'b01, a}; endfunction
    function automatic logic [9:0] dl(input logic [7:0] a); return {2'b10, a}; endfunction
    function automatic logic [9:0] e_end();                 return {2'b11, 8'h00}; endfunction

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // Called once per falling edge: checks hold-stability, then drives tx_ready.
    task automatic drive_ready(input bit always_rdy, input int stall);
        if (wait_prev && !(tx_valid && {tx_dc, tx_data} == prev_byte)) stable_errs++;
        if (tx_valid) hold++; else hold = 0;
        tx_ready  = always_rdy ? 1'b1 : (tx_valid && hold > stall);
        wait_prev = tx_valid && !tx_ready;
        prev_byte = {tx_dc, tx_data};
    endtask

    task automatic run_vector(input vec_t v, input int idx);
        int k, rel, first, lat;
        for (int i = 0; i < 5; i++) rom[i] = v.rom[i];
        hs_q.delete();
        stable_errs = 0; busy_errs = 0; hold = 0; wait_prev = 1'b0;
        first = -1; lat = -1;
        @(negedge clk);
        start = 1'b1;
        k = cyc + 1;
        drive_ready(v.always_ready, v.stall);
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            rel = cyc - k;
            start = (v.repulse != 0 && rel == v.repulse);
            drive_ready(v.always_ready, v.stall);
            if (tx_valid && first < 0) first = rel;
            if (done) begin
                lat = rel;
                break;
            end
            if (!busy) busy_errs++;
        end
        start = 1'b0;
        check($sformatf("v%0d done_latency", idx), lat, v.latency);
        check($sformatf("v%0d first_valid", idx), first, v.first_valid);
        check($sformatf("v%0d busy_at_done", idx), int'(busy), 0);
        check($sformatf("v%0d busy_gaps", idx), busy_errs, 0);
        check($sformatf("v%0d hold_unstable", idx), stable_errs, 0);
        check($sformatf("v%0d handshakes", idx), hs_q.size(), v.n_bytes);
        for (int j = 0; j < v.n_bytes; j++)
            check($sformatf("v%0d byte%0d", idx, j),
                  (j < hs_q.size()) ? int'(hs_q[j]) : -1, int'(v.bytes[j]));
        @(negedge clk);
        drive_ready(v.always_ready, v.stall);
        check($sformatf("v%0d done_after", idx), int'(done), 0);
        check($sformatf("v%0d busy_after", idx), int'(busy), 0);
    endtask

    initial begin
        bit seen;
        for (int i = 0; i < 8; i++) rom[i] = e_end();

        vecs[0] = '0;
        vecs[0].rom = {c(8'h00), e_end(), d(8'h80), c(8'hD5), c(8'hAE)};
        vecs[0].always_ready = 1'b1;
        vecs[0].n_bytes = 3;
        vecs[0].bytes = {9'h000, 9'h000, 9'h180, 9'h0D5, 9'h0AE};
        vecs[0].latency = 7;
        vecs[0].first_valid = 1;

        vecs[1] = vecs[0];
        vecs[1].always_ready = 1'b0;
        vecs[1].stall = 5;
        vecs[1].latency = 22;

        vecs[2] = '0;
        vecs[2].rom = {e_end(), c(8'h22), dl(8'd0), c(8'h11), dl(8'd3)};
        vecs[2].n_bytes = 2;
        vecs[2].bytes = {9'h000, 9'h000, 9'h000, 9'h022, 9'h011};
        vecs[2].latency = 19;
        vecs[2].first_valid = 14;

        vecs[3] = '0;
        vecs[3].rom = {c(8'h05), c(8'h04), c(8'h03), c(8'h02), c(8'h01)};
        vecs[3].always_ready = 1'b1;
        vecs[3].n_bytes = 5;
        vecs[3].bytes = {9'h005, 9'h004, 9'h003, 9'h002, 9'h001};
        vecs[3].latency = 11;
        vecs[3].first_valid = 1;

        vecs[4] = '0;
        vecs[4].rom = {c(8'h01), c(8'h01), c(8'h01), c(8'h01), e_end()};
        vecs[4].always_ready = 1'b1;
        vecs[4].latency = 1;
        vecs[4].first_valid = -1;

        vecs[5] = '0;
        vecs[5].rom = {c(8'h77), e_end(), d(8'h00), dl(8'd1), d(8'hFF)};
        vecs[5].n_bytes = 2;
        vecs[5].bytes = {9'h000, 9'h000, 9'h000, 9'h100, 9'h1FF};
        vecs[5].latency = 10;
        vecs[5].first_valid = 1;

        vecs[6] = vecs[0];
        vecs[6].repulse = 3;

        v_restart = '0;
        v_restart.rom = {e_end(), d(8'h80), c(8'hD5), c(8'hAE), dl(8'd0)};
        v_restart.always_ready = 1'b1;
        v_restart.n_bytes = 3;
        v_restart.bytes = {9'h000, 9'h000, 9'h180, 9'h0D5, 9'h0AE};
        v_restart.latency = 8;
        v_restart.first_valid = 2;

        repeat (2) @(negedge clk);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset tx_valid", int'(tx_valid), 0);
        check("reset tx_data", int'(tx_data), 0);
        check("reset tx_dc", int'(tx_dc), 0);
        check("reset rom_address", int'(rom_address), 0);
        reset_n = 1'b1;

        for (int i = 0; i < 7; i++) run_vector(vecs[i], i);

        // Reset asserted while a byte is waiting for the transmitter.
        for (int i = 0; i < 5; i++) rom[i] = v_restart.rom[i];
        hold = 0; wait_prev = 1'b0;
        @(negedge clk);
        start = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start = 1'b0;
            drive_ready(1'b0, 1000);
            if (tx_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("rst tx_valid_seen", int'(seen), 1);
        check("rst address_in_send", int'(rom_address), 1);
        reset_n = 1'b0;
        #1;
        check("rst async tx_valid", int'(tx_valid), 0);
        check("rst async busy", int'(busy), 0);
        check("rst async rom_address", int'(rom_address), 0);
        check("rst async tx_data", int'(tx_data), 0);
        @(negedge clk);
        reset_n = 1'b1;
        run_vector(v_restart, 7);

        // start held high across DONE relaunches from IDLE.
        for (int i = 0; i < 5; i++) rom[i] = vecs[0].rom[i];
        hs_q.delete();
        hold = 0; wait_prev = 1'b0;
        @(negedge clk);
        start = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            drive_ready(1'b1, 0);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("held first_done", int'(seen), 1);
        @(negedge clk);
        drive_ready(1'b1, 0);
        check("held idle_busy", int'(busy), 0);
        check("held idle_done", int'(done), 0);
        @(negedge clk);
        drive_ready(1'b1, 0);
        check("held relaunch_busy", int'(busy), 1);
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            drive_ready(1'b1, 0);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("held second_done", int'(seen), 1);
        check("held handshakes", hs_q.size(), 6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
